// File: rtl/cc_sidecomparator_dir.sv
// Ball-position side comparator with direction tracking.
// Watches a one-hot position bus on strobed samples, reports when the ball
// sits at the left/right edge (active-low levels), pulses once on entry to
// an edge, tracks the direction of travel and counts edge hits.
// Non-one-hot samples are flagged and otherwise ignored.
// Legal parameters: RIGHTPOS < LEFTPOS < DATAWIDTH.

module cc_sidecomparator_dir #(
  parameter int SIDECOMPARATOR_DATAWIDTH  = 8,
  parameter int SIDECOMPARATOR_LEFTPOS    = 7,
  parameter int SIDECOMPARATOR_RIGHTPOS   = 4,
  parameter int SIDECOMPARATOR_COUNTWIDTH = 8
) (
  input  logic                                 CC_SIDECOMPARATOR_DIR_CLOCK_50,
  input  logic                                 CC_SIDECOMPARATOR_DIR_RESET_InHigh,
  input  logic                                 CC_SIDECOMPARATOR_DIR_sample_In,
  input  logic [SIDECOMPARATOR_DATAWIDTH-1:0]  CC_SIDECOMPARATOR_DIR_data_InBUS,
  output logic                                 CC_SIDECOMPARATOR_DIR_izquierda_OutLow,
  output logic                                 CC_SIDECOMPARATOR_DIR_derecha_OutLow,
  output logic                                 CC_SIDECOMPARATOR_DIR_hitIzquierda_OutLow,
  output logic                                 CC_SIDECOMPARATOR_DIR_hitDerecha_OutLow,
  output logic                                 CC_SIDECOMPARATOR_DIR_dir_Out,
  output logic                                 CC_SIDECOMPARATOR_DIR_active_Out,
  output logic [SIDECOMPARATOR_COUNTWIDTH-1:0] CC_SIDECOMPARATOR_DIR_hitCount_OutBUS,
  output logic                                 CC_SIDECOMPARATOR_DIR_invalid_Out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOV_IZQ = 2'd1,
    MOV_DER = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Edge levels double as the record of where the last valid sample was:
  // a low level means the last valid sample sat on that edge.
  logic izq_q, izq_d;
  logic der_q, der_d;
  logic hit_izq_q, hit_izq_d;
  logic hit_der_q, hit_der_d;
  logic inv_q, inv_d;
  logic [SIDECOMPARATOR_COUNTWIDTH-1:0] cnt_q, cnt_d;

  logic clk;
  logic rst;
  logic onehot;
  logic valid;
  logic at_left;
  logic at_right;
  logic hit_left;
  logic hit_right;

  assign clk      = CC_SIDECOMPARATOR_DIR_CLOCK_50;
  assign rst      = CC_SIDECOMPARATOR_DIR_RESET_InHigh;
  assign onehot   = $onehot(CC_SIDECOMPARATOR_DIR_data_InBUS);
  assign valid    = CC_SIDECOMPARATOR_DIR_sample_In && onehot;
  assign at_left  = valid && CC_SIDECOMPARATOR_DIR_data_InBUS[SIDECOMPARATOR_LEFTPOS];
  assign at_right = valid && CC_SIDECOMPARATOR_DIR_data_InBUS[SIDECOMPARATOR_RIGHTPOS];
  // Entry to an edge only counts when the previous valid sample was elsewhere.
  assign hit_left  = at_left  && izq_q;
  assign hit_right = at_right && der_q;

  // State register; reset wins over any simultaneous sample.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: only valid samples move the direction FSM.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned
    // and no latch is inferred.
    state_d = state_q;
    if (valid) begin
      unique case (state_q)
        IDLE:    state_d = at_left ? MOV_DER : MOV_IZQ;
        MOV_IZQ: if (at_left)  state_d = MOV_DER;
        MOV_DER: if (at_right) state_d = MOV_IZQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    CC_SIDECOMPARATOR_DIR_dir_Out    = (state_q == MOV_DER);
    CC_SIDECOMPARATOR_DIR_active_Out = (state_q != IDLE);
  end

  // Next values for edge levels, hit pulses, counter and invalid flag.
  always_comb begin
    izq_d     = izq_q;
    der_d     = der_q;
    hit_izq_d = ~hit_left;
    hit_der_d = ~hit_right;
    inv_d     = CC_SIDECOMPARATOR_DIR_sample_In && !onehot;
    cnt_d     = cnt_q;
    if (valid) begin
      izq_d = ~at_left;
      der_d = ~at_right;
    end
    // Left and right hits are mutually exclusive for a one-hot sample.
    if ((hit_left || hit_right) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath registers with synchronous reset to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      izq_q     <= 1'b1;
      der_q     <= 1'b1;
      hit_izq_q <= 1'b1;
      hit_der_q <= 1'b1;
      inv_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      izq_q     <= izq_d;
      der_q     <= der_d;
      hit_izq_q <= hit_izq_d;
      hit_der_q <= hit_der_d;
      inv_q     <= inv_d;
      cnt_q     <= cnt_d;
    end
  end

  assign CC_SIDECOMPARATOR_DIR_izquierda_OutLow    = izq_q;
  assign CC_SIDECOMPARATOR_DIR_derecha_OutLow      = der_q;
  assign CC_SIDECOMPARATOR_DIR_hitIzquierda_OutLow = hit_izq_q;
  assign CC_SIDECOMPARATOR_DIR_hitDerecha_OutLow   = hit_der_q;
  assign CC_SIDECOMPARATOR_DIR_hitCount_OutBUS     = cnt_q;
  assign CC_SIDECOMPARATOR_DIR_invalid_Out         = inv_q;

endmodule

// File: doc/cc_sidecomparator_dir.md
CC_SIDECOMPARATOR_DIR -- requirements
Module: cc_sidecomparator_dir

Parameters
REQ-001 SHALL have SIDECOMPARATOR_DATAWIDTH, default 8, width of the position bus.
REQ-002 SHALL have SIDECOMPARATOR_LEFTPOS, default 7, bit index of the left edge.
REQ-003 SHALL have SIDECOMPARATOR_RIGHTPOS, default 4, bit index of the right edge; SIDECOMPARATOR_RIGHTPOS < SIDECOMPARATOR_LEFTPOS < DATAWIDTH; other values are illegal.
REQ-004 SHALL have SIDECOMPARATOR_COUNTWIDTH, default 8, width of the hit counter.

Interface
REQ-005 CC_SIDECOMPARATOR_DIR_CLOCK_50  input  1  single clock, all state on rising edge.
REQ-006 CC_SIDECOMPARATOR_DIR_RESET_InHigh  input  1  reset, synchronous, active-high.
REQ-007 CC_SIDECOMPARATOR_DIR_sample_In  input  1  strobe; bus sampled only on clocks where high.
REQ-008 CC_SIDECOMPARATOR_DIR_data_InBUS  input  DATAWIDTH  ball position, one-hot expected.
REQ-009 CC_SIDECOMPARATOR_DIR_izquierda_OutLow  output  1  registered level, low while last valid sample is at LEFTPOS.
REQ-010 CC_SIDECOMPARATOR_DIR_derecha_OutLow  output  1  registered level, low while last valid sample is at RIGHTPOS.
REQ-011 CC_SIDECOMPARATOR_DIR_hitIzquierda_OutLow  output  1  one-clock low pulse on entry to left edge.
REQ-012 CC_SIDECOMPARATOR_DIR_hitDerecha_OutLow  output  1  one-clock low pulse on entry to right edge.
REQ-013 CC_SIDECOMPARATOR_DIR_dir_Out  output  1  movement direction: 1 = toward right (index decreasing), 0 = toward left.
REQ-014 CC_SIDECOMPARATOR_DIR_active_Out  output  1  high once a valid position has been seen since reset.
REQ-015 CC_SIDECOMPARATOR_DIR_hitCount_OutBUS  output  COUNTWIDTH  total edge hits since reset.
REQ-016 CC_SIDECOMPARATOR_DIR_invalid_Out  output  1  one-clock high pulse for a non-one-hot sample.

Function
REQ-017 A sample is valid iff sample_In=1 and data_InBUS has exactly one bit set.
REQ-018 All outputs SHALL be registered; response appears on the clock edge following the sampling edge (latency 1).
REQ-019 With sample_In=0 all level outputs, state, counter SHALL hold; pulse outputs SHALL be inactive.
REQ-020 FSM states: IDLE, MOV_IZQ, MOV_DER; dir_Out=1 only in MOV_DER; active_Out=0 only in IDLE.
REQ-021 IDLE -> MOV_DER on valid sample at LEFTPOS; -> MOV_IZQ on valid sample at any other position.
REQ-022 MOV_IZQ -> MOV_DER on valid sample at LEFTPOS; MOV_DER -> MOV_IZQ on valid sample at RIGHTPOS; otherwise hold.
REQ-023 Valid sample at RIGHTPOS while in MOV_IZQ SHALL also force MOV_IZQ (no change); valid sample at LEFTPOS while in MOV_DER holds MOV_DER.
REQ-024 Edge level outputs SHALL reflect the most recent valid sample only; both high when it is not at an edge.
REQ-025 Hit pulse SHALL fire only when the previous valid sample was not at the same edge; repeated samples at an edge yield one pulse.
REQ-026 Each hit pulse SHALL increment hitCount by 1; counter saturates at all-ones, never wraps.
REQ-027 A sample with zero or multiple bits set SHALL raise invalid_Out for one clock and change nothing else; the "previous valid sample" remains the last valid one.
REQ-028 Positions between edges or outside [RIGHTPOS, LEFTPOS] SHALL be accepted as valid, not hits.

Reset
REQ-029 On clock edge with RESET_InHigh=1: state IDLE, dir_Out=0, active_Out=0, izquierda_OutLow=1, derecha_OutLow=1, both hit outputs=1, hitCount=0, invalid_Out=0, previous-sample record cleared.
REQ-030 Reset SHALL take priority over a simultaneous sample; reset mid-movement discards all history.

Verification
REQ-031 Reset, then sample 8'b10000000 -> next clock izquierda_OutLow=0, hitIzquierda_OutLow=0 one clock, dir_Out=1, hitCount=1, active_Out=1.
REQ-032 Sweep 0x80,0x40,0x20,0x10 (one sample each) -> derecha pulse on 0x10, dir_Out=0, hitCount=2.
REQ-033 Sample 0x10 three consecutive strobes -> single derecha pulse, derecha_OutLow stays 0, hitCount +1 only.
REQ-034 Sample 0x00 then 0x18 -> invalid_Out pulses twice, levels/state/counter unchanged.
REQ-035 COUNTWIDTH=2, alternate edges 5 times -> hitCount sticks at 3.
REQ-036 Reset asserted together with sample 0x80 mid-sweep -> all outputs at reset values, state IDLE next clock.
